// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the AES MixColumns blocks.
//   - mc_state_e     : FSM state encoding of the sequential MixColumns engine
//   - AES_POLY_LOW   : low byte of the AES reduction polynomial 0x11b
//   - COL_W/NUM_COLS : column slicing of a 128-bit state (column c = [32c+31:32c],
//                      row 0 in the least-significant byte); shared with the
//                      inverse MixColumns block so both agree on ordering
//   - xtime          : multiply by {02} in GF(2^8)
//   - mix_col        : forward MixColumns on one 32-bit column
//   - get_col/put_col: column read / column replace helpers
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_e;

  localparam logic [7:0] AES_POLY_LOW = 8'h1b;

  localparam int BYTE_W   = 8;
  localparam int COL_W    = 32;
  localparam int NUM_COLS = 4;
  localparam int STATE_W  = COL_W * NUM_COLS;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY_LOW : 8'h00);
  endfunction

  // Circulant matrix {02,03,01,01}; 3x is expressed as xtime(x)^x.
  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = a[7:0];
    a1 = a[15:8];
    a2 = a[23:16];
    a3 = a[31:24];
    b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [COL_W-1:0] get_col(input logic [STATE_W-1:0] s,
                                               input logic [1:0] c);
    return s[COL_W*c +: COL_W];
  endfunction

  function automatic logic [STATE_W-1:0] put_col(input logic [STATE_W-1:0] s,
                                                 input logic [1:0] c,
                                                 input logic [COL_W-1:0] v);
    logic [STATE_W-1:0] r;
    r = s;
    r[COL_W*c +: COL_W] = v;
    return r;
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// mix_single_column: combinational forward MixColumns of one column.
//   col_in  [31:0] : input column, row 0 in bits [7:0]
//   col_out [31:0] : mixed column, same byte ordering
module mix_single_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  assign col_out = mix_col(col_in);

endmodule

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: multi-cycle, handshaked forward AES MixColumns engine.
// A state is accepted into an internal register, then COLS_PER_CYCLE columns
// are mixed in place per clock until all four are done; the result is then
// presented until downstream takes it.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The source keeps in_valid/in_data steady until in_ready;
// out_valid/out_data stay frozen until out_ready. in_ready depends only on
// FSM state and out_ready, never on in_valid.
//
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset
//   in_valid   : in_data holds a state to accept
//   in_ready   : block accepts a state this cycle
//   in_data    : 128-bit input state (sampled on the accept edge only)
//   out_valid  : out_data holds a finished result (registered)
//   out_ready  : downstream takes out_data
//   out_data   : 128-bit MixColumns result (registered)
//   dbg_state  : current FSM state encoding (mc_state_e)
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic [1:0]         dbg_state
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // A step of 4 truncates to 0, which is exactly the 2-bit wrap we want.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(NUM_COLS - COLS_PER_CYCLE);

  mc_state_e          state_q, state_d;
  logic [1:0]         col_idx_q, col_idx_d;
  logic [STATE_W-1:0] data_q, data_d;
  logic               out_valid_q, out_valid_d;

  logic [1:0]       grp_idx [COLS_PER_CYCLE];
  logic [COL_W-1:0] col_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0] col_out [COLS_PER_CYCLE];

  // Column group currently being mixed: col_idx .. col_idx+COLS_PER_CYCLE-1.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign grp_idx[g] = col_idx_q + 2'(g);
    assign col_in[g]  = get_col(data_q, grp_idx[g]);

    mix_single_column u_mix (
      .col_in  (col_in[g]),
      .col_out (col_out[g])
    );
  end

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    data_d    = data_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d    = in_data;
          col_idx_d = 2'd0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          data_d = put_col(data_d, grp_idx[g], col_out[g]);
        end
        col_idx_d = col_idx_q + COL_STEP;
        if (col_idx_q == LAST_COL) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            data_d    = in_data;
            col_idx_d = 2'd0;
            state_d   = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      col_idx_q   <= 2'd0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // The state register only holds the finished result while DONE.
  assign out_data  = data_q;
  assign out_valid = out_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: one DUT per legal COLS_PER_CYCLE (1, 2, 4), each
// with its own driver, ready generator, expected queue and monitor. The
// reference model does GF(2^8) matrix arithmetic from first principles and
// also supplies the inverse matrix for the round-trip check.
module tb_mix_columns_seq;
  import aes_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit done_flag [3];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    int x;
    p = 0;
    x = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11b;
    end
    return p[7:0];
  endfunction

  // Column-wise circulant matrix product; coefficient for input row j in
  // output row r is m[(j - r) mod 4].
  function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inverse);
    logic [7:0]   m [4];
    logic [127:0] res;
    logic [7:0]   acc;
    if (inverse) begin
      m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    end else begin
      m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gf_mul(s[8*(4*c+j) +: 8], m[(j - r + 4) % 4]);
        end
        res[8*(4*c+r) +: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int CPC = 1 << gi;
    localparam int LAT = 4 / CPC;

    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [1:0]   dbg_state;

    int rdy_mode = 0;  // 0 random, 1 always ready, 2 never ready

    logic [127:0] exp_q [$];
    logic [127:0] src_q [$];
    int           acc_q [$];

    mix_columns_seq #(.COLS_PER_CYCLE(CPC)) u_dut (
      .clk       (clk),
      .reset     (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .dbg_state (dbg_state)
    );

    function automatic string tag(input string name);
      return $sformatf("cpc%0d_%s", CPC, name);
    endfunction

    task automatic set_mode(input int m);
      rdy_mode  = m;
      out_ready = (m == 1);
    endtask

    initial begin
      out_ready = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
        else out_ready = (rdy_mode == 1);
      end
    end

    // Monitor: latency on each new result, stability under back-pressure,
    // data and round-trip check on each released result.
    initial begin
      bit           prev_valid;
      bit           prev_hs;
      logic [127:0] prev_data;
      logic [127:0] e;
      logic [127:0] s;
      prev_valid = 0;
      prev_hs    = 0;
      prev_data  = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          prev_valid = 0;
          prev_hs    = 0;
        end else begin
          if (prev_valid && !prev_hs) begin
            chk(tag("hold_valid"), 128'(out_valid), 128'(1));
            chk(tag("hold_data"), out_data, prev_data);
          end
          if (out_valid && (!prev_valid || prev_hs)) begin
            if (acc_q.size() == 0) fail_now(tag("unexpected_output"));
            else chk(tag("latency"), 128'(cyc - acc_q[0]), 128'(LAT));
          end
          if (out_valid && !out_ready) begin
            chk(tag("bp_in_ready"), 128'(in_ready), 128'(0));
          end
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              fail_now(tag("release_without_accept"));
            end else begin
              e = exp_q.pop_front();
              s = src_q.pop_front();
              void'(acc_q.pop_front());
              chk(tag("data"), out_data, e);
              chk(tag("round_trip"), mix_model(out_data, 1'b1), s);
            end
          end
          prev_valid = out_valid;
          prev_hs    = out_valid && out_ready;
          prev_data  = out_data;
        end
      end
    end

    // Starts at posedge+1 and returns at posedge+1 after the accept edge
    // (or after the busy-phase noise, if requested).
    task automatic send(input logic [127:0] d, input logic [127:0] e,
                        input bit noisy, input bit first_try);
      bit ok;
      ok       = 0;
      in_valid = 1'b1;
      in_data  = d;
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1;
          exp_q.push_back(e);
          src_q.push_back(d);
          acc_q.push_back(cyc + 1);
          if (first_try) chk(tag("same_edge_accept"), 128'(t), 128'(0));
        end
      end
      if (!ok) fail_now(tag("accept_timeout"));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = rand128();
      if (noisy) begin
        for (int t = 0; t < 10; t++) begin
          in_valid = 1'($urandom_range(0, 1));
          in_data  = rand128();
          @(negedge clk);
          if (out_valid) begin
            in_valid = 1'b0;
            break;
          end
          chk(tag("busy_in_ready"), 128'(in_ready), 128'(0));
          @(posedge clk);
          #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    endtask

    task automatic wait_drain();
      for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(negedge clk);
      if (exp_q.size() != 0) fail_now(tag("drain_timeout"));
      @(posedge clk);
      #1;
    endtask

    initial begin
      logic [31:0]  cv_in  [5];
      logic [31:0]  cv_out [5];
      logic [7:0]   r1_in  [16];
      logic [7:0]   r1_out [16];
      logic [127:0] d;
      logic [127:0] e;
      logic [127:0] x;

      cv_in  = '{32'h455313db, 32'h5c220af2, 32'h01010101, 32'hc6c6c6c6, 32'hd5d4d4d4};
      cv_out = '{32'hbca14d8e, 32'h9d58dc9f, 32'h01010101, 32'hc6c6c6c6, 32'hd6d7d5d5};
      r1_in  = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                 8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
      r1_out = '{8'h04, 8'h66, 8'h81, 8'he5, 8'he0, 8'hcb, 8'h19, 8'h9a,
                 8'h48, 8'hf8, 8'hd3, 8'h7a, 8'h28, 8'h06, 8'h26, 8'h4c};

      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      set_mode(0);
      #1;
      chk(tag("rst_out_valid"), 128'(out_valid), 128'(0));
      chk(tag("rst_out_data"), out_data, 128'(0));
      chk(tag("rst_in_ready"), 128'(in_ready), 128'(1));
      chk(tag("rst_state"), 128'(dbg_state), 128'(IDLE));
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Known column vectors in every column position; other columns hold
      // 01010101, which MixColumns leaves unchanged.
      set_mode(1);
      for (int v = 0; v < 5; v++) begin
        for (int p = 0; p < 4; p++) begin
          d = {4{32'h01010101}};
          e = {4{32'h01010101}};
          d[32*p +: 32] = cv_in[v];
          e[32*p +: 32] = cv_out[v];
          send(d, e, 0, 0);
        end
      end
      wait_drain();

      for (int k = 0; k < 16; k++) begin
        d[8*k +: 8] = r1_in[k];
        e[8*k +: 8] = r1_out[k];
      end
      send(d, e, 0, 0);
      send({128{1'b0}}, {128{1'b0}}, 0, 0);
      send({128{1'b1}}, {128{1'b1}}, 0, 0);
      wait_drain();

      // Back-pressure, then release together with the next accept.
      set_mode(2);
      x = rand128();
      send(x, mix_model(x, 1'b0), 0, 0);
      for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
      if (!out_valid) fail_now(tag("bp_valid_timeout"));
      repeat (10) @(negedge clk);
      @(posedge clk);
      #1;
      set_mode(1);
      x = rand128();
      send(x, mix_model(x, 1'b0), 0, 1);
      wait_drain();

      // Reset two edges after accept discards the state in flight.
      set_mode(2);
      x = rand128();
      send(x, mix_model(x, 1'b0), 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk(tag("midrst_out_valid"), 128'(out_valid), 128'(0));
      chk(tag("midrst_out_data"), out_data, 128'(0));
      chk(tag("midrst_in_ready"), 128'(in_ready), 128'(1));
      exp_q.delete();
      src_q.delete();
      acc_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      set_mode(0);
      x = rand128();
      send(x, mix_model(x, 1'b0), 0, 0);
      wait_drain();

      // Noisy input while busy, then random traffic.
      for (int i = 0; i < 4; i++) begin
        x = rand128();
        send(x, mix_model(x, 1'b0), 1, 0);
      end
      for (int i = 0; i < 2500; i++) begin
        x = rand128();
        send(x, mix_model(x, 1'b0), ($urandom_range(0, 15) == 0), 0);
        if ($urandom_range(0, 7) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
      wait_drain();
      done_flag[gi] = 1;
    end
  end

  initial begin
    bit all_done;
    all_done = 0;
    for (int t = 0; t < 90000 && !all_done; t++) begin
      @(posedge clk);
      all_done = done_flag[0] && done_flag[1] && done_flag[2];
    end
    if (!all_done) fail_now("global_timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
